hangman_round_ctrl: RTL and testbench

- Round-sequencing FSM for the hangman game datapath.
- Drives word entry into the character RAM (ram32v5-style, 1-cycle read latency), then scans the stored word for each player-2 guess.
- Issues reveal/draw commands to the display path and maintains both players' scores.
- Sits between keyboard/switch decode, the character RAM, the guess timer and the VGA drawing datapath.

---
 rtl/hangman_pkg.sv | 39 +++
 rtl/hangman_scan.sv | 51 +++++
 rtl/hangman_round_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hangman_round_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types and defaults for the hangman round controller: state encoding,
// size defaults, character codes and a word-length mask helper.
package hangman_pkg;

  localparam int CHAR_W_DEF    = 5;
  localparam int MAX_LEN_DEF   = 16;
  localparam int MAX_PARTS_DEF = 9;
  localparam int SCORE_W_DEF   = 8;
  localparam int LEN_W         = 6;
  localparam int ADDR_W        = 5;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_GUESS  = 3'd1,
    ST_SCAN   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Character codes as produced by the keyboard decode (A = 0).
  localparam logic [4:0] CH_A = 5'd0;
  localparam logic [4:0] CH_B = 5'd1;
  localparam logic [4:0] CH_C = 5'd2;
  localparam logic [4:0] CH_D = 5'd3;
  localparam logic [4:0] CH_E = 5'd4;
  localparam logic [4:0] CH_F = 5'd5;
  localparam logic [4:0] CH_G = 5'd6;
  localparam logic [4:0] CH_H = 5'd7;

  // One bit set for every stored character position.
  function automatic logic [31:0] len_mask(input logic [LEN_W-1:0] len);
    if (len >= 6'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'h1 << len) - 32'h1;
    end
  endfunction

endpackage

// File: rtl/hangman_scan.sv
// Word scanner: walks RAM addresses 0..len-1 while active and compares the
// returned data one cycle later against the latched guess.
module hangman_scan
  import hangman_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_active,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [CHAR_W-1:0] i_guess,
  input  logic [CHAR_W-1:0] i_ram_q,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_match,
  output logic [ADDR_W-1:0] o_match_idx,
  output logic              o_done
);

  logic [LEN_W-1:0]  r_addr;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_idx;
  logic              w_addr_en;

  assign w_addr_en = i_active && (r_addr < i_len);

  // Address counter plus one-stage tag that lines up with the RAM read latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= 6'd0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= 5'd0;
    end else if (!i_active) begin
      r_addr      <= 6'd0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= 5'd0;
    end else if (w_addr_en) begin
      r_addr      <= r_addr + 6'd1;
      r_cmp_valid <= 1'b1;
      r_cmp_idx   <= r_addr[ADDR_W-1:0];
    end else begin
      r_cmp_valid <= 1'b0;
    end
  end

  assign o_addr      = w_addr_en ? r_addr[ADDR_W-1:0] : 5'd0;
  assign o_match     = r_cmp_valid && (i_ram_q == i_guess);
  assign o_match_idx = r_cmp_idx;
  assign o_done      = r_cmp_valid && ({1'b0, r_cmp_idx} == (i_len - 6'd1));

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round sequencer: word entry, guess scanning, reveal/draw commands
// and scoring. Define HANGMAN_REPEAT_PENALTY_EN to punish repeated guesses.
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int MAX_PARTS = MAX_PARTS_DEF,
  parameter int CHAR_W    = CHAR_W_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [CHAR_W-1:0]  key_char,
  input  logic               key_valid,
  input  logic               key_enter,
  input  logic               timeout,
  input  logic [CHAR_W-1:0]  ram_q,
  output logic [4:0]         ram_addr,
  output logic [CHAR_W-1:0]  ram_data,
  output logic               ram_wren,
  output logic [4:0]         word_len,
  output logic               reveal_we,
  output logic [4:0]         reveal_idx,
  output logic               draw_part,
  output logic [3:0]         part_count,
  output logic               timer_clr,
  output logic               timer_run,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [2:0]         state_o
);

  state_e             r_state, w_next_state;
  logic [LEN_W-1:0]   r_word_len;
  logic [3:0]         r_part_count;
  logic [31:0]        r_revealed;
  logic               r_pend, r_hit, r_any_match;
  logic [CHAR_W-1:0]  r_guess;
  logic [SCORE_W-1:0] r_p1, r_p2;
  logic               r_timer_clr, r_draw;

  logic               w_wr, w_new_reveal, w_all_rev, w_miss, w_pend_now;
  logic               w_go_guess, w_p1_inc, w_p2_inc, w_draw, w_clear_round, w_latch_guess;
  logic               w_match, w_scan_done;
  logic [4:0]         w_scan_addr, w_match_idx;
  logic [31:0]        w_len_mask;
  logic [3:0]         w_parts_next;

  hangman_scan #(.CHAR_W(CHAR_W)) u_scan (
    .clk        (clk),
    .resetn     (resetn),
    .i_active   (r_state == ST_SCAN),
    .i_len      (r_word_len),
    .i_guess    (r_guess),
    .i_ram_q    (ram_q),
    .o_addr     (w_scan_addr),
    .o_match    (w_match),
    .o_match_idx(w_match_idx),
    .o_done     (w_scan_done)
  );

  assign w_wr         = (r_state == ST_LOAD) && key_valid && (r_word_len < LEN_W'(MAX_LEN));
  assign w_new_reveal = w_match && !r_revealed[w_match_idx];
  assign w_len_mask   = len_mask(r_word_len);
  assign w_all_rev    = ((r_revealed & w_len_mask) == w_len_mask);
  assign w_parts_next = r_part_count + 4'd1;
  assign w_pend_now   = r_pend || timeout;
`ifdef HANGMAN_REPEAT_PENALTY_EN
  assign w_miss       = !r_hit;
`else
  assign w_miss       = !r_any_match;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    w_next_state  = r_state;
    w_go_guess    = 1'b0;
    w_p1_inc      = 1'b0;
    w_p2_inc      = 1'b0;
    w_draw        = 1'b0;
    w_clear_round = 1'b0;
    w_latch_guess = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (key_enter && ((r_word_len != 6'd0) || w_wr)) begin
          w_next_state = ST_GUESS;
          w_go_guess   = 1'b1;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_GUESS: begin
        if (timeout) begin
          w_p1_inc     = 1'b1;
          w_next_state = ST_DONE;
        end else if (key_valid) begin
          w_latch_guess = 1'b1;
          w_next_state  = ST_SCAN;
        end else begin
          w_next_state = ST_GUESS;
        end
      end
      ST_SCAN: begin
        if (w_scan_done) begin
          w_next_state = ST_UPDATE;
        end else begin
          w_next_state = ST_SCAN;
        end
      end
      ST_UPDATE: begin
        if (w_all_rev) begin
          w_p2_inc     = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_miss) begin
          w_draw = 1'b1;
          if ((w_parts_next == 4'(MAX_PARTS)) || w_pend_now) begin
            w_p1_inc     = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_go_guess   = 1'b1;
            w_next_state = ST_GUESS;
          end
        end else if (w_pend_now) begin
          w_p1_inc     = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_go_guess   = 1'b1;
          w_next_state = ST_GUESS;
        end
      end
      ST_DONE: begin
        if (key_enter) begin
          w_clear_round = 1'b1;
          w_next_state  = ST_LOAD;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: begin
        w_next_state = ST_LOAD;
      end
    endcase
  end

  // Round datapath: word length, revealed bitmap, guess flags, parts, scores and pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_word_len   <= 6'd0;
      r_part_count <= 4'd0;
      r_revealed   <= 32'd0;
      r_pend       <= 1'b0;
      r_hit        <= 1'b0;
      r_any_match  <= 1'b0;
      r_guess      <= {CHAR_W{1'b0}};
      r_p1         <= {SCORE_W{1'b0}};
      r_p2         <= {SCORE_W{1'b0}};
      r_timer_clr  <= 1'b0;
      r_draw       <= 1'b0;
    end else begin
      r_timer_clr <= w_go_guess;
      r_draw      <= w_draw;
      if (w_clear_round) begin
        r_word_len   <= 6'd0;
        r_part_count <= 4'd0;
        r_revealed   <= 32'd0;
        r_pend       <= 1'b0;
      end else begin
        if (w_wr) r_word_len <= r_word_len + 6'd1;
        if (w_draw) r_part_count <= w_parts_next;
        if (w_new_reveal) r_revealed[w_match_idx] <= 1'b1;
        if (timeout && ((r_state == ST_SCAN) || (r_state == ST_UPDATE))) r_pend <= 1'b1;
      end
      if (w_latch_guess) begin
        r_guess     <= key_char;
        r_hit       <= 1'b0;
        r_any_match <= 1'b0;
      end else begin
        if (w_new_reveal) r_hit <= 1'b1;
        if (w_match) r_any_match <= 1'b1;
      end
      // Scores stick at all-ones rather than wrapping.
      if (w_p1_inc && (r_p1 != {SCORE_W{1'b1}})) r_p1 <= r_p1 + SCORE_W'(1'b1);
      if (w_p2_inc && (r_p2 != {SCORE_W{1'b1}})) r_p2 <= r_p2 + SCORE_W'(1'b1);
    end
  end

  assign ram_wren   = w_wr;
  assign ram_addr   = w_wr ? r_word_len[4:0] : w_scan_addr;
  assign ram_data   = w_wr ? key_char : {CHAR_W{1'b0}};
  assign word_len   = r_word_len[4:0];
  assign reveal_we  = w_new_reveal;
  assign reveal_idx = w_new_reveal ? w_match_idx : 5'd0;
  assign draw_part  = r_draw;
  assign part_count = r_part_count;
  assign timer_clr  = r_timer_clr;
  assign timer_run  = (r_state == ST_GUESS) || (r_state == ST_SCAN) || (r_state == ST_UPDATE);
  assign p1_score   = r_p1;
  assign p2_score   = r_p2;
  assign state_o    = r_state;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Self-checking bench for hangman_round_ctrl: directed round scenarios plus
// random rounds scored against a set-based reference model of the game rules.
module tb_hangman_round_ctrl;
  import hangman_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] key_char = 5'd0;
  logic       key_valid = 1'b0, key_enter = 1'b0, timeout = 1'b0;
  logic [4:0] ram_q = 5'd0;
  logic [4:0] ram_addr, ram_data, word_len, reveal_idx;
  logic       ram_wren, reveal_we, draw_part, timer_clr, timer_run;
  logic [3:0] part_count;
  logic [7:0] p1_score, p2_score;
  logic [2:0] state_o;

  hangman_round_ctrl dut (
    .clk(clk), .resetn(resetn), .key_char(key_char), .key_valid(key_valid),
    .key_enter(key_enter), .timeout(timeout), .ram_q(ram_q), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_wren(ram_wren), .word_len(word_len),
    .reveal_we(reveal_we), .reveal_idx(reveal_idx), .draw_part(draw_part),
    .part_count(part_count), .timer_clr(timer_clr), .timer_run(timer_run),
    .p1_score(p1_score), .p2_score(p2_score), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Character RAM with one-cycle read latency.
  logic [4:0] mem [0:31];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  // Event counters sampled mid-cycle.
  int mon_rev_cnt [0:31];
  int mon_draw = 0, mon_clr = 0, mon_wr = 0, mon_scan = 0;
  initial for (int i = 0; i < 32; i++) mon_rev_cnt[i] = 0;
  always @(negedge clk) begin
    if (reveal_we) mon_rev_cnt[reveal_idx] <= mon_rev_cnt[reveal_idx] + 1;
    if (draw_part) mon_draw <= mon_draw + 1;
    if (timer_clr) mon_clr <= mon_clr + 1;
    if (ram_wren) mon_wr <= mon_wr + 1;
    if (state_o == ST_SCAN) mon_scan <= mon_scan + 1;
  end

  int s_rev [0:31];
  int s_draw, s_clr, s_wr, s_scan;
  int n_checks = 0, n_err = 0;

  // Reference model of the round.
  logic [4:0] t_word [0:31];
  logic [4:0] m_word [0:31];
  bit         m_rev [0:31];
  int         m_len, m_parts, m_p1, m_p2;
  bit         m_pend, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 32; i++) s_rev[i] = mon_rev_cnt[i];
    s_draw = mon_draw; s_clr = mon_clr; s_wr = mon_wr; s_scan = mon_scan;
  endtask

  task automatic pulse_valid(input logic [4:0] c);
    tick(); key_char = c; key_valid = 1'b1;
    tick(); key_valid = 1'b0;
  endtask

  task automatic pulse_enter();
    tick(); key_enter = 1'b1;
    tick(); key_enter = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_state"}, state_o, 0);
    check({pfx, "_word_len"}, word_len, 0);
    check({pfx, "_parts"}, part_count, 0);
    check({pfx, "_p1"}, p1_score, 0);
    check({pfx, "_p2"}, p2_score, 0);
    check({pfx, "_outs"}, {ram_wren, reveal_we, draw_part, timer_clr, timer_run}, 0);
    check({pfx, "_addr"}, {ram_addr, ram_data, reveal_idx}, 0);
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : v;
  endfunction

  // Apply one guess to the model; returns newly revealed positions and expected pulses.
  task automatic model_guess(input logic [4:0] g, output logic [31:0] new_mask,
                             output int exp_draw, output int exp_clr);
    bit any, win, miss;
    new_mask = 32'd0; any = 1'b0; exp_draw = 0; exp_clr = 0;
    for (int i = 0; i < m_len; i++) begin
      if (m_word[i] == g) begin
        any = 1'b1;
        if (!m_rev[i]) begin new_mask[i] = 1'b1; m_rev[i] = 1'b1; end
      end
    end
    win = 1'b1;
    for (int i = 0; i < m_len; i++) if (!m_rev[i]) win = 1'b0;
`ifdef HANGMAN_REPEAT_PENALTY_EN
    miss = (new_mask == 32'd0);
`else
    miss = !any;
`endif
    if (win) begin
      m_p2 = sat_inc(m_p2); m_done = 1'b1;
    end else if (miss) begin
      exp_draw = 1; m_parts++;
      if (m_parts == MAX_PARTS_DEF || m_pend) begin m_p1 = sat_inc(m_p1); m_done = 1'b1; end
      else exp_clr = 1;
    end else if (m_pend) begin
      m_p1 = sat_inc(m_p1); m_done = 1'b1;
    end else exp_clr = 1;
  endtask

  task automatic check_round_state(input string pfx);
    check({pfx, "_parts"}, part_count, m_parts);
    check({pfx, "_p1"}, p1_score, m_p1);
    check({pfx, "_p2"}, p2_score, m_p2);
    check({pfx, "_state"}, state_o, m_done ? 32'(ST_DONE) : 32'(ST_GUESS));
  endtask

  task automatic do_guess(input logic [4:0] g, input bit inject);
    logic [31:0] exp_mask, got_mask;
    int exp_draw, exp_clr, n, multi;
    snap();
    if (inject) m_pend = 1'b1;
    model_guess(g, exp_mask, exp_draw, exp_clr);
    pulse_valid(g);
    if (inject) begin tick(); timeout = 1'b1; tick(); timeout = 1'b0; end
    n = 0;
    while ((state_o == ST_SCAN || state_o == ST_UPDATE) && n < 200) begin tick(); n++; end
    check("guess_bound", (n < 200) ? 32'd1 : 32'd0, 1);
    settle();
    got_mask = 32'd0; multi = 0;
    for (int i = 0; i < 32; i++) begin
      if (mon_rev_cnt[i] != s_rev[i]) got_mask[i] = 1'b1;
      if (mon_rev_cnt[i] - s_rev[i] > 1) multi++;
    end
    check("reveal_mask", got_mask, exp_mask);
    check("reveal_once", multi, 0);
    check("scan_cycles", mon_scan - s_scan, m_len + 1);
    check("draw_pulses", mon_draw - s_draw, exp_draw);
    check("clr_pulses", mon_clr - s_clr, exp_clr);
    check_round_state("guess");
  endtask

  task automatic do_timeout();
    snap();
    m_p1 = sat_inc(m_p1); m_done = 1'b1;
    tick(); timeout = 1'b1; tick(); timeout = 1'b0;
    settle();
    check("to_clr", mon_clr - s_clr, 0);
    check("to_timer_run", timer_run, 0);
    check_round_state("timeout");
  endtask

  task automatic new_round(input int len);
    int exp_len, bad;
    if (state_o == ST_DONE) begin
      pulse_enter(); settle();
      check("to_load_state", state_o, ST_LOAD);
      check("to_load_len", word_len, 0);
      check("to_load_parts", part_count, 0);
    end
    exp_len = (len > MAX_LEN_DEF) ? MAX_LEN_DEF : len;
    m_len = exp_len; m_parts = 0; m_pend = 1'b0; m_done = 1'b0;
    for (int i = 0; i < 32; i++) begin m_rev[i] = 1'b0; m_word[i] = t_word[i]; end
    snap();
    for (int i = 0; i < len; i++) pulse_valid(t_word[i]);
    settle();
    check("load_word_len", word_len, exp_len);
    check("load_writes", mon_wr - s_wr, exp_len);
    bad = 0;
    for (int i = 0; i < exp_len; i++) if (mem[i] !== t_word[i]) bad++;
    check("load_ram", bad, 0);
    snap();
    pulse_enter(); settle();
    check("enter_state", state_o, ST_GUESS);
    check("enter_clr", mon_clr - s_clr, 1);
    check("enter_timer_run", timer_run, 1);
  endtask

  task automatic play_random();
    int g = 0;
    while (!m_done && g < 40) begin
      if ($urandom_range(0, 11) == 0) do_timeout();
      else do_guess(5'($urandom_range(0, 7)), 1'b0);
      g++;
    end
    if (!m_done) do_timeout();
  endtask

  initial begin
    int rl;
    m_p1 = 0; m_p2 = 0; m_done = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 5'd0;
    tick(); tick();
    check_all_zero("rst_hold");
    resetn = 1'b1;
    settle();
    check_all_zero("rst_rel");

    // Word 3,1,2: one hit, then nine misses.
    t_word[0] = CH_D; t_word[1] = CH_B; t_word[2] = CH_C;
    new_round(3);
    do_guess(CH_B, 1'b0);
    check("hit_parts_zero", part_count, 0);
    for (int k = 0; k < 9; k++) do_guess(CH_H, 1'b0);
    check("nine_miss_parts", part_count, 9);
    check("nine_miss_p1", p1_score, 1);
    check("nine_miss_done", state_o, ST_DONE);
    check("done_timer_run", timer_run, 0);

    // Same word, repeated guess before the win.
    new_round(3);
    do_guess(CH_B, 1'b0);
    do_guess(CH_B, 1'b0);
`ifdef HANGMAN_REPEAT_PENALTY_EN
    check("repeat_parts", part_count, 1);
`else
    check("repeat_parts", part_count, 0);
`endif
    do_guess(CH_D, 1'b0);
    do_guess(CH_C, 1'b0);
    check("win_p2", p2_score, 1);
    check("win_done", state_o, ST_DONE);

    // Timeout while waiting for a guess.
    new_round(3);
    do_timeout();
    check("guess_timeout_p1", p1_score, 2);

    // Timeout during the scan of the winning guess: win still counts.
    new_round(3);
    do_guess(CH_D, 1'b0);
    do_guess(CH_B, 1'b0);
    do_guess(CH_C, 1'b1);
    check("late_to_p2", p2_score, 2);
    check("late_to_p1", p1_score, 2);

    // Empty word is rejected, overlong word is truncated.
    pulse_enter(); settle();
    snap();
    pulse_enter(); settle();
    check("empty_enter_state", state_o, ST_LOAD);
    check("empty_enter_clr", mon_clr - s_clr, 0);
    for (int i = 0; i < 17; i++) t_word[i] = 5'($urandom_range(0, 5));
    new_round(17);
    check("max_len", word_len, 16);
    play_random();

    // Random rounds.
    for (int r = 0; r < 6; r++) begin
      rl = $urandom_range(1, 16);
      for (int i = 0; i < rl; i++) t_word[i] = 5'($urandom_range(0, 5));
      new_round(rl);
      play_random();
    end

    // Reset in the middle of a scan.
    for (int i = 0; i < 8; i++) t_word[i] = CH_E;
    new_round(8);
    pulse_valid(CH_E);
    tick();
    snap();
    resetn = 1'b0;
    #1;
    check_all_zero("rst_scan");
    tick(); tick(); tick();
    settle();
    check("rst_scan_reveals", mon_rev_cnt[0] + mon_rev_cnt[1] + mon_rev_cnt[7]
          - s_rev[0] - s_rev[1] - s_rev[7], 0);
    check("rst_scan_draws", mon_draw - s_draw, 0);
    check_all_zero("rst_scan_hold");
    resetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
